// File: rtl/alm_psum_accumulator.sv
// Partial-sum accumulator behind the ALM multiplier: sums acc_len products per group and
// hands the group sum downstream over valid/ready. Build macro ALM_ACC_SAT_EN selects saturation.
module alm_psum_accumulator #(
    parameter int PROD_BW = 64,
    parameter int ACC_BW  = 72,
    parameter int CNT_BW  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [CNT_BW-1:0] acc_len,
    input  logic              prod_valid,
    input  logic [PROD_BW-1:0] prod_data,
    output logic              prod_ready,
    output logic              sum_valid,
    output logic [ACC_BW-1:0] sum_data,
    output logic              sum_ovf,
    input  logic              sum_ready
);

    // Handshake: a word moves on a rising edge where valid & ready are both high; valid never
    // waits on ready, and a held sum keeps sum_data/sum_ovf stable until it moves.
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t            state_q, state_d;
    logic [ACC_BW-1:0] acc_q, acc_d;
    logic [CNT_BW-1:0] cnt_q, cnt_d;
    logic [CNT_BW-1:0] len_q, len_d;
    logic              ovf_q, ovf_d;

    logic              prod_xfer;
    logic              sum_xfer;
    logic [ACC_BW-1:0] prod_ext;
    logic [ACC_BW:0]   sum_ext;
    logic              carry;
    logic [CNT_BW-1:0] len_eff;
    logic [CNT_BW-1:0] cnt_inc;

    assign prod_ready = (state_q != HOLD);
    assign sum_valid  = (state_q == HOLD);
    assign sum_data   = sum_valid ? acc_q : '0;
    assign sum_ovf    = sum_valid & ovf_q;

    assign prod_xfer = prod_valid & prod_ready;
    assign sum_xfer  = sum_valid & sum_ready;
    assign prod_ext  = ACC_BW'(prod_data);
    assign sum_ext   = {1'b0, acc_q} + {1'b0, prod_ext};
    assign carry     = sum_ext[ACC_BW];
    assign len_eff   = (acc_len == '0) ? CNT_BW'(1) : acc_len;
    assign cnt_inc   = cnt_q + CNT_BW'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        if (clear) begin
            // Flush wins over everything, including a product presented this cycle.
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (prod_xfer) begin
                        acc_d   = prod_ext;
                        cnt_d   = CNT_BW'(1);
                        ovf_d   = 1'b0;
                        len_d   = len_eff;
                        state_d = (len_eff == CNT_BW'(1)) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (prod_xfer) begin
`ifdef ALM_ACC_SAT_EN
                        acc_d = carry ? '1 : sum_ext[ACC_BW-1:0];
`else
                        acc_d = sum_ext[ACC_BW-1:0];
`endif
                        ovf_d = ovf_q | carry;
                        cnt_d = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (sum_xfer) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_alm_psum_accumulator.sv
// Bench for alm_psum_accumulator: directed group/backpressure/clear/reset steps on a 64/72
// instance, overflow steps on an 8/8 instance, then randomized groups against a sum model.
module tb_alm_psum_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [7:0]  acc_len;
    logic        prod_valid;
    logic [63:0] prod_data;
    logic        prod_ready;
    logic        sum_valid;
    logic [71:0] sum_data;
    logic        sum_ovf;
    logic        sum_ready;

    logic        o_clear;
    logic [7:0]  o_acc_len;
    logic        o_valid;
    logic [7:0]  o_data;
    logic        o_pready;
    logic        o_svalid;
    logic [7:0]  o_sdata;
    logic        o_sovf;
    logic        o_sready;

    int checks = 0;
    int errors = 0;
    bit rand_mode = 1'b0;
    bit mon_en = 1'b0;
    logic [72:0] exp_q[$];

    always #5 clk = ~clk;

    alm_psum_accumulator #(.PROD_BW(64), .ACC_BW(72), .CNT_BW(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .acc_len(acc_len),
        .prod_valid(prod_valid), .prod_data(prod_data), .prod_ready(prod_ready),
        .sum_valid(sum_valid), .sum_data(sum_data), .sum_ovf(sum_ovf), .sum_ready(sum_ready)
    );

    alm_psum_accumulator #(.PROD_BW(8), .ACC_BW(8), .CNT_BW(8)) u_ovf (
        .clk(clk), .rst_n(rst_n), .clear(o_clear), .acc_len(o_acc_len),
        .prod_valid(o_valid), .prod_data(o_data), .prod_ready(o_pready),
        .sum_valid(o_svalid), .sum_data(o_sdata), .sum_ovf(o_sovf), .sum_ready(o_sready)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting posedge.
    task automatic send_prod(input logic [63:0] d);
        bit ok;
        ok = 1'b0;
        prod_data  = d;
        prod_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (prod_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("prod_accept_timeout", 0, 1);
        @(negedge clk);
        prod_valid = 1'b0;
    endtask

    // Sum monitor: owns sum_ready during the random phase; checks each sum as it is about to move.
    always @(negedge clk) begin
        logic [72:0] e;
        if (rand_mode) sum_ready = ($urandom_range(0, 1) == 1);
        if (mon_en && sum_valid === 1'b1 && sum_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rand_unexpected_sum", {sum_ovf, sum_data}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rand_sum", {sum_ovf, sum_data}, e);
            end
        end
    end

    initial begin
        logic [127:0] tot;
        int           len;
        rst_n = 1'b0; clear = 1'b0; acc_len = 8'd0; prod_valid = 1'b0; prod_data = '0;
        sum_ready = 1'b1;
        o_clear = 1'b0; o_acc_len = 8'd0; o_valid = 1'b0; o_data = '0; o_sready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_sum_data", sum_data, 0);
        chk("rst_sum_ovf", sum_ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_prod_ready", prod_ready, 1);

        // Basic group of four
        acc_len = 8'd4;
        send_prod(64'd10);
        send_prod(64'd20);
        send_prod(64'd30);
        chk("basic_no_early_valid", sum_valid, 0);
        send_prod(64'd40);
        chk("basic_valid", sum_valid, 1);
        chk("basic_data", sum_data, 100);
        chk("basic_ovf", sum_ovf, 0);
        chk("basic_bubble", prod_ready, 0);
        @(negedge clk);
        chk("basic_valid_one_cycle", sum_valid, 0);
        chk("basic_ready_again", prod_ready, 1);

        // Length 0 and 1 both make single-product groups
        for (int l = 0; l < 2; l++) begin
            acc_len = 8'(l);
            send_prod(64'hFFFF_FFFF_FFFF_FFFF);
            chk("len01_valid", sum_valid, 1);
            chk("len01_data", sum_data, 72'h00_FFFF_FFFF_FFFF_FFFF);
            @(negedge clk);
            chk("len01_drop", sum_valid, 0);
        end

        // Backpressure holds the sum stable
        sum_ready = 1'b0;
        acc_len = 8'd2;
        send_prod(64'd5);
        send_prod(64'd7);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", sum_valid, 1);
            chk("bp_data", sum_data, 12);
            chk("bp_prod_ready", prod_ready, 0);
            @(negedge clk);
        end
        sum_ready = 1'b1;
        @(negedge clk);
        chk("bp_released_valid", sum_valid, 0);
        chk("bp_released_ready", prod_ready, 1);

        // clear mid-group drops the product presented with it
        acc_len = 8'd4;
        send_prod(64'd1);
        send_prod(64'd2);
        clear = 1'b1; prod_valid = 1'b1; prod_data = 64'd3;
        @(negedge clk);
        clear = 1'b0; prod_valid = 1'b0;
        chk("clear_no_sum", sum_valid, 0);
        chk("clear_ready", prod_ready, 1);
        acc_len = 8'd2;
        send_prod(64'd8);
        chk("clear_mid_no_sum", sum_valid, 0);
        send_prod(64'd9);
        chk("clear_new_valid", sum_valid, 1);
        chk("clear_new_data", sum_data, 17);
        @(negedge clk);

        // Async reset while holding a sum
        sum_ready = 1'b0;
        acc_len = 8'd1;
        send_prod(64'h55);
        chk("arst_hold_valid", sum_valid, 1);
        #2 rst_n = 1'b0;
        #1 chk("arst_valid_drop", sum_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sum_ready = 1'b1;
        @(negedge clk);
        chk("arst_prod_ready", prod_ready, 1);
        chk("arst_sum_data", sum_data, 0);
        chk("arst_sum_valid", sum_valid, 0);

        // Overflow on the 8-bit instance
        o_acc_len = 8'd2;
        o_valid = 1'b1; o_data = 8'd200;
        @(negedge clk);
        o_data = 8'd100;
        @(negedge clk);
        o_valid = 1'b0;
        chk("ovf_valid", o_svalid, 1);
`ifdef ALM_ACC_SAT_EN
        chk("ovf_data", o_sdata, 255);
`else
        chk("ovf_data", o_sdata, 44);
`endif
        chk("ovf_flag", o_sovf, 1);
        @(negedge clk);
        o_acc_len = 8'd3;
        o_valid = 1'b1; o_data = 8'd200;
        @(negedge clk);
        o_data = 8'd100;
        @(negedge clk);
        o_data = 8'd0;
        @(negedge clk);
        o_valid = 1'b0;
`ifdef ALM_ACC_SAT_EN
        chk("ovf3_data", o_sdata, 255);
`else
        chk("ovf3_data", o_sdata, 44);
`endif
        chk("ovf3_flag", o_sovf, 1);
        @(negedge clk);
        o_acc_len = 8'd2;
        o_valid = 1'b1; o_data = 8'd100;
        @(negedge clk);
        o_data = 8'd50;
        @(negedge clk);
        o_valid = 1'b0;
        chk("noovf_data", o_sdata, 150);
        chk("noovf_flag", o_sovf, 0);
        @(negedge clk);

        // Randomized groups with gaps, backpressure and mid-group acc_len changes
        mon_en = 1'b1;
        rand_mode = 1'b1;
        for (int g = 0; g < 40; g++) begin
            acc_len = 8'($urandom_range(0, 5));
            len = (acc_len == 8'd0) ? 1 : int'(acc_len);
            tot = '0;
            for (int i = 0; i < len; i++) begin
                logic [63:0] d;
                d = {$urandom, $urandom};
                tot = tot + {64'd0, d};
                if (i == len - 1) exp_q.push_back({|tot[127:72], tot[71:0]});
                send_prod(d);
                acc_len = 8'($urandom_range(0, 7));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
        chk("rand_drained", exp_q.size(), 0);
        rand_mode = 1'b0;
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
